alu_result_checker: RTL and testbench
=====================================

# alu_result_checker

Synthesizable, self-checking monitor that sits beside the 8-bit ALU and observes the same operand/opcode stream the ALU consumes plus the result the ALU produces. It recomputes each expected result, compares it against the ALU output after a fixed ALU latency, and publishes per-check pulses, saturating pass/fail counters and a capture of the first failing transaction. It is the consuming end of the ALU operand/result interface and is used both in on-chip BIST and as a drop-in scoreboard in simulation.

## Interface
- `WIDTH`, 8: operand/result width in bits.
- `ALU_LAT`, 0: ALU result latency in cycles. 0 means combinational. Legal range 0–4.
- `CNT_W`, 16: width of the pass and fail counters.
- `clk` input, 1: single clock, rising edge.
- `reset_n` input, 1: asynchronous, active-low reset.
- `clear_i` input, 1: synchronous clear of counters, capture registers, state and in-flight checks.
- `valid_i` input, 1: `a_i`/`b_i`/`op_i` carry a transaction this cycle.
- `a_i` input, WIDTH: operand A.
- `b_i` input, WIDTH: operand B.
- `op_i` input, 3: opcode.
- `alu_i` input, WIDTH: observed ALU output.
- `chk_valid_o` output, 1: one-cycle pulse; a comparison completed.
- `mismatch_o` output, 1: qualified by `chk_valid_o`; the observed result differed from the expected result.
- `err_o` output, 1: sticky; at least one mismatch since reset or clear.
- `pass_cnt_o` output, CNT_W: saturating count of matches.
- `fail_cnt_o` output, CNT_W: saturating count of mismatches.
- `ff_op_o` output, 3: opcode of the first failing transaction.
- `ff_a_o` output, WIDTH: operand A of the first failing transaction.
- `ff_b_o` output, WIDTH: operand B of the first failing transaction.
- `ff_exp_o` output, WIDTH: expected result of the first failing transaction.
- `ff_got_o` output, WIDTH: observed result of the first failing transaction.

## Operation
- **Opcode map.** All arithmetic is modulo 2^WIDTH.
  - 000 ADD: a+b
  - 001 SUB: a−b
  - 010 SLL: a << b[$clog2(WIDTH)-1:0]
  - 011 SRL: logical a >> b[$clog2(WIDTH)-1:0]
  - 100 AND
  - 101 OR
  - 110 XOR
  - 111 EQ: result is {WIDTH-1 zeros, (a==b)}
- **Pipeline.** The expected result is computed combinationally from `a_i`/`b_i`/`op_i` when `valid_i` is high. It then travels with its operands and opcode through an ALU_LAT-deep delay line, one entry per cycle, so back-to-back transactions are supported. When the delayed valid reaches the end of the line, `alu_i` is sampled that cycle and compared.
- **FSM.** States are IDLE, RUN and FAIL.
  - IDLE → RUN on the first completed check that matches.
  - IDLE or RUN → FAIL on any completed check that mismatches.
  - FAIL is held until `clear_i` or reset.
  - `err_o` = (state == FAIL).
- **First-failure capture.** The `ff_*` registers load only on the mismatch that causes entry into FAIL. Later mismatches do not overwrite them.
- **Counters.** Each counter increments by 1 per completed check and saturates at all-ones; it never wraps.
- **Clear.** `clear_i` wins over a simultaneous check completion. Counters return to 0, state returns to IDLE, `ff_*` return to 0 and the delay line is flushed. A `valid_i` in the same cycle as `clear_i` is dropped.
- **Reset.** Asynchronous reset mid-operation has the same effect as clear. After reset all outputs are 0 and the state is IDLE.

## Timing
- A transaction with `valid_i` high in cycle t has its `alu_i` sampled in cycle t+ALU_LAT.
- `chk_valid_o`/`mismatch_o` are registered and pulse in cycle t+ALU_LAT+1.
- Counters, `err_o` and `ff_*` show the updated values in that same cycle t+ALU_LAT+1.
- Throughput is one check per cycle. There is no backpressure and no input ready.
- If `valid_i` is low in cycle t, nothing is checked in cycle t+ALU_LAT and `alu_i` is ignored.

## Structure
- **Shared package `alu_pkg`:**
  - `alu_op_e` enum (ADD=3'b000 … EQ=3'b111)
  - `OP_W`=3
  - checker state enum `chk_state_e`
  - these types and constants are shared with the ALU and its benches
- **Sub-module `alu_ref_model`:** purely combinational; inputs a, b, op; output expected result; parameter WIDTH. It is instantiated once at the input stage.
- **Top level:** the delay line (a generate-selected register chain, bypassed when ALU_LAT=0), the compare register, the FSM, the counters and the capture registers.

## Test plan
- **All eight opcodes, ALU_LAT=0, correct ALU.** Drive these transactions on consecutive cycles:
  - ADD FF,55 → 54
  - SUB 5E,07 → 57
  - SLL 07,70 → 07
  - SRL 15,70 → 15
  - AND 66,18 → 00
  - OR 06,79 → 7F
  - XOR 0F,74 → 7B
  - EQ 7F,7F → 01

  Required response: 8 `chk_valid_o` pulses starting 1 cycle after the first `valid_i`, `mismatch_o`=0 throughout, `pass_cnt_o`=8, `err_o`=0.
- **Single corrupted result.** On the 3rd transaction force `alu_i`=08 instead of 07 (SLL 07,70). Required response: `mismatch_o` pulses on that check only; `err_o`=1 and stays 1; `fail_cnt_o`=1; `ff_op_o`=010, `ff_a_o`=07, `ff_b_o`=70, `ff_exp_o`=07, `ff_got_o`=08. A second corruption later leaves all `ff_*` unchanged.
- **ALU_LAT=2 back-to-back.** Issue 4 consecutive valid transactions with a registered ALU model. Required response: `chk_valid_o` is high in cycles t+3 … t+6; all match.
- **Counter saturation.** Use CNT_W=4 and issue 20 matching checks. Required response: `pass_cnt_o` stops at F.
- **Clear collision.** Assert `clear_i` in the same cycle a mismatch completes. Required response: next cycle `fail_cnt_o`=0, `err_o`=0, state is IDLE, no capture.
- **Reset mid-stream.** Use ALU_LAT=2 with 2 transactions in flight and pulse `reset_n` low. Required response: all outputs are 0 immediately, and no `chk_valid_o` appears afterward for the flushed transactions.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU opcode map and result-checker state types.
// Imported by the ALU, the result checker and their benches.
package alu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    SLL = 3'b010,
    SRL = 3'b011,
    AND = 3'b100,
    OR  = 3'b101,
    XOR = 3'b110,
    EQ  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FAIL = 2'd2
  } chk_state_e;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden model of the ALU.
// Produces the expected result for one operand/opcode set.
module alu_ref_model
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  alu_op_e          op_i,
  output logic [WIDTH-1:0] exp_o
);

  localparam int SH_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [SH_W-1:0] sh;

  assign sh = b_i[SH_W-1:0];

  always_comb begin
    exp_o = '0;
    unique case (op_i)
      ADD: exp_o = a_i + b_i;
      SUB: exp_o = a_i - b_i;
      SLL: exp_o = a_i << sh;
      SRL: exp_o = a_i >> sh;
      AND: exp_o = a_i & b_i;
      OR:  exp_o = a_i | b_i;
      XOR: exp_o = a_i ^ b_i;
      EQ:  exp_o = {{(WIDTH-1){1'b0}}, a_i == b_i};
    endcase
  end

endmodule

// File: rtl/alu_result_checker.sv
// Self-checking ALU monitor: delays expected results by the
// ALU latency, compares, counts and captures the first failure.
module alu_result_checker
  import alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int ALU_LAT = 0,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [OP_W-1:0]  op_i,
  input  logic [WIDTH-1:0] alu_i,
  output logic             chk_valid_o,
  output logic             mismatch_o,
  output logic             err_o,
  output logic [CNT_W-1:0] pass_cnt_o,
  output logic [CNT_W-1:0] fail_cnt_o,
  output logic [OP_W-1:0]  ff_op_o,
  output logic [WIDTH-1:0] ff_a_o,
  output logic [WIDTH-1:0] ff_b_o,
  output logic [WIDTH-1:0] ff_exp_o,
  output logic [WIDTH-1:0] ff_got_o
);

  localparam logic [CNT_W-1:0] CNT_ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  logic             in_v;
  logic [WIDTH-1:0] in_exp;

  logic             ln_v;
  logic [OP_W-1:0]  ln_op;
  logic [WIDTH-1:0] ln_a;
  logic [WIDTH-1:0] ln_b;
  logic [WIDTH-1:0] ln_exp;

  logic             hit;
  logic             miss;

  chk_state_e       state_q;
  logic             chk_valid_q;
  logic             mismatch_q;
  logic [CNT_W-1:0] pass_cnt_q;
  logic [CNT_W-1:0] fail_cnt_q;
  logic [CNT_W-1:0] pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_d;
  logic [OP_W-1:0]  ff_op_q;
  logic [WIDTH-1:0] ff_a_q;
  logic [WIDTH-1:0] ff_b_q;
  logic [WIDTH-1:0] ff_exp_q;
  logic [WIDTH-1:0] ff_got_q;

  // A transaction issued alongside clear is dropped.
  assign in_v = valid_i & ~clear_i;

  alu_ref_model #(
    .WIDTH(WIDTH)
  ) u_ref (
    .a_i  (a_i),
    .b_i  (b_i),
    .op_i (alu_op_e'(op_i)),
    .exp_o(in_exp)
  );

  if (ALU_LAT == 0) begin : g_bypass
    assign ln_v   = in_v;
    assign ln_op  = op_i;
    assign ln_a   = a_i;
    assign ln_b   = b_i;
    assign ln_exp = in_exp;
  end else begin : g_line
    logic             v_q   [ALU_LAT];
    logic [OP_W-1:0]  op_q  [ALU_LAT];
    logic [WIDTH-1:0] a_q   [ALU_LAT];
    logic [WIDTH-1:0] b_q   [ALU_LAT];
    logic [WIDTH-1:0] exp_q [ALU_LAT];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < ALU_LAT; i++) begin
          v_q[i]   <= 1'b0;
          op_q[i]  <= '0;
          a_q[i]   <= '0;
          b_q[i]   <= '0;
          exp_q[i] <= '0;
        end
      end else if (clear_i) begin
        for (int i = 0; i < ALU_LAT; i++) begin
          v_q[i]   <= 1'b0;
          op_q[i]  <= '0;
          a_q[i]   <= '0;
          b_q[i]   <= '0;
          exp_q[i] <= '0;
        end
      end else begin
        v_q[0]   <= in_v;
        op_q[0]  <= op_i;
        a_q[0]   <= a_i;
        b_q[0]   <= b_i;
        exp_q[0] <= in_exp;
        for (int i = 1; i < ALU_LAT; i++) begin
          v_q[i]   <= v_q[i-1];
          op_q[i]  <= op_q[i-1];
          a_q[i]   <= a_q[i-1];
          b_q[i]   <= b_q[i-1];
          exp_q[i] <= exp_q[i-1];
        end
      end
    end

    assign ln_v   = v_q[ALU_LAT-1];
    assign ln_op  = op_q[ALU_LAT-1];
    assign ln_a   = a_q[ALU_LAT-1];
    assign ln_b   = b_q[ALU_LAT-1];
    assign ln_exp = exp_q[ALU_LAT-1];
  end

  assign hit  = ln_v & ~clear_i;
  assign miss = hit & (alu_i != ln_exp);

  always_comb begin
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    if (hit && !miss && pass_cnt_q != '1) begin
      pass_cnt_d = pass_cnt_q + CNT_ONE;
    end
    if (miss && fail_cnt_q != '1) begin
      fail_cnt_d = fail_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      chk_valid_q <= 1'b0;
      mismatch_q  <= 1'b0;
      pass_cnt_q  <= '0;
      fail_cnt_q  <= '0;
      ff_op_q     <= '0;
      ff_a_q      <= '0;
      ff_b_q      <= '0;
      ff_exp_q    <= '0;
      ff_got_q    <= '0;
    end else if (clear_i) begin
      state_q     <= IDLE;
      chk_valid_q <= 1'b0;
      mismatch_q  <= 1'b0;
      pass_cnt_q  <= '0;
      fail_cnt_q  <= '0;
      ff_op_q     <= '0;
      ff_a_q      <= '0;
      ff_b_q      <= '0;
      ff_exp_q    <= '0;
      ff_got_q    <= '0;
    end else begin
      chk_valid_q <= hit;
      mismatch_q  <= miss;
      pass_cnt_q  <= pass_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      unique case (state_q)
        IDLE, RUN: begin
          if (miss) begin
            state_q  <= FAIL;
            ff_op_q  <= ln_op;
            ff_a_q   <= ln_a;
            ff_b_q   <= ln_b;
            ff_exp_q <= ln_exp;
            ff_got_q <= alu_i;
          end else if (hit) begin
            state_q <= RUN;
          end
        end
        FAIL: state_q <= FAIL;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign chk_valid_o = chk_valid_q;
  assign mismatch_o  = mismatch_q;
  assign err_o       = (state_q == FAIL);
  assign pass_cnt_o  = pass_cnt_q;
  assign fail_cnt_o  = fail_cnt_q;
  assign ff_op_o     = ff_op_q;
  assign ff_a_o      = ff_a_q;
  assign ff_b_o      = ff_b_q;
  assign ff_exp_o    = ff_exp_q;
  assign ff_got_o    = ff_got_q;

endmodule

// File: tb/tb_alu_result_checker.sv
// Bench for alu_result_checker: three instances (latency 0/2/1)
// driven in lockstep and scored against a transaction-level model.
module tb_alu_result_checker;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clear;
  logic       valid;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;

  logic [7:0]  alu_d [N];
  logic        cv    [N];
  logic        mm    [N];
  logic        er    [N];
  logic [15:0] pc    [N];
  logic [15:0] fc    [N];
  logic [2:0]  fop   [N];
  logic [7:0]  fa    [N];
  logic [7:0]  fb    [N];
  logic [7:0]  fe    [N];
  logic [7:0]  fg    [N];
  logic [3:0]  pc4;
  logic [3:0]  fc4;

  always #5 clk = ~clk;

  alu_result_checker #(.WIDTH(8), .ALU_LAT(0), .CNT_W(16)) u_l0 (
    .clk(clk), .reset_n(reset_n), .clear_i(clear), .valid_i(valid),
    .a_i(a), .b_i(b), .op_i(op), .alu_i(alu_d[0]),
    .chk_valid_o(cv[0]), .mismatch_o(mm[0]), .err_o(er[0]),
    .pass_cnt_o(pc[0]), .fail_cnt_o(fc[0]), .ff_op_o(fop[0]),
    .ff_a_o(fa[0]), .ff_b_o(fb[0]), .ff_exp_o(fe[0]), .ff_got_o(fg[0])
  );

  alu_result_checker #(.WIDTH(8), .ALU_LAT(2), .CNT_W(16)) u_l2 (
    .clk(clk), .reset_n(reset_n), .clear_i(clear), .valid_i(valid),
    .a_i(a), .b_i(b), .op_i(op), .alu_i(alu_d[1]),
    .chk_valid_o(cv[1]), .mismatch_o(mm[1]), .err_o(er[1]),
    .pass_cnt_o(pc[1]), .fail_cnt_o(fc[1]), .ff_op_o(fop[1]),
    .ff_a_o(fa[1]), .ff_b_o(fb[1]), .ff_exp_o(fe[1]), .ff_got_o(fg[1])
  );

  alu_result_checker #(.WIDTH(8), .ALU_LAT(1), .CNT_W(4)) u_c4 (
    .clk(clk), .reset_n(reset_n), .clear_i(clear), .valid_i(valid),
    .a_i(a), .b_i(b), .op_i(op), .alu_i(alu_d[2]),
    .chk_valid_o(cv[2]), .mismatch_o(mm[2]), .err_o(er[2]),
    .pass_cnt_o(pc4), .fail_cnt_o(fc4), .ff_op_o(fop[2]),
    .ff_a_o(fa[2]), .ff_b_o(fb[2]), .ff_exp_o(fe[2]), .ff_got_o(fg[2])
  );

  assign pc[2] = {12'd0, pc4};
  assign fc[2] = {12'd0, fc4};

  typedef struct packed {
    logic       v;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] e;
    logic [7:0] g;
  } txn_t;

  txn_t       pend [N][6];
  logic [7:0] aq   [N][6];
  int         m_pass [N];
  int         m_fail [N];
  bit         m_err  [N];
  bit         m_cv   [N];
  bit         m_mm   [N];
  logic [2:0] m_op   [N];
  logic [7:0] m_a    [N];
  logic [7:0] m_b    [N];
  logic [7:0] m_e    [N];
  logic [7:0] m_g    [N];
  int         checks = 0;
  int         errors = 0;

  logic [2:0] t_op [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [7:0] t_a  [8] = '{8'hFF, 8'h5E, 8'h07, 8'h15,
                           8'h66, 8'h06, 8'h0F, 8'h7F};
  logic [7:0] t_b  [8] = '{8'h55, 8'h07, 8'h70, 8'h70,
                           8'h18, 8'h79, 8'h74, 8'h7F};
  logic [7:0] t_r  [8] = '{8'h54, 8'h57, 8'h07, 8'h15,
                           8'h00, 8'h7F, 8'h7B, 8'h01};

  function automatic int lat(input int k);
    return (k == 0) ? 0 : (k == 1) ? 2 : 1;
  endfunction

  function automatic int cmax(input int k);
    return (k == 2) ? 15 : 65535;
  endfunction

  function automatic logic [7:0] ref_alu(input logic [2:0] o,
                                         input logic [7:0] x,
                                         input logic [7:0] y);
    int s;
    s = int'(y) % 8;
    case (o)
      3'd0: return 8'(int'(x) + int'(y));
      3'd1: return 8'(int'(x) - int'(y) + 256);
      3'd2: return 8'(int'(x) * (1 << s));
      3'd3: return 8'(int'(x) / (1 << s));
      3'd4: return x & y;
      3'd5: return x | y;
      3'd6: return x ^ y;
      default: return (x == y) ? 8'd1 : 8'd0;
    endcase
  endfunction

  task automatic chk(input string nm, input int k,
                     input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got=%h want=%h t=%0t",
               nm, k, got, exp, $time);
    end
  endtask

  task automatic model_clear(input int k);
    for (int i = 0; i < 6; i++) pend[k][i] = '0;
    m_pass[k] = 0;
    m_fail[k] = 0;
    m_err[k]  = 1'b0;
    m_cv[k]   = 1'b0;
    m_mm[k]   = 1'b0;
    m_op[k]   = '0;
    m_a[k]    = '0;
    m_b[k]    = '0;
    m_e[k]    = '0;
    m_g[k]    = '0;
  endtask

  task automatic model_edge(input bit clr);
    txn_t c;
    for (int k = 0; k < N; k++) begin
      if (clr) begin
        model_clear(k);
      end else begin
        c = pend[k][0];
        m_cv[k] = c.v;
        m_mm[k] = c.v && (c.e != c.g);
        if (c.v && c.e != c.g) begin
          if (m_fail[k] < cmax(k)) m_fail[k]++;
          if (!m_err[k]) begin
            m_err[k] = 1'b1;
            m_op[k]  = c.op;
            m_a[k]   = c.a;
            m_b[k]   = c.b;
            m_e[k]   = c.e;
            m_g[k]   = c.g;
          end
        end else if (c.v) begin
          if (m_pass[k] < cmax(k)) m_pass[k]++;
        end
        for (int i = 0; i < 5; i++) pend[k][i] = pend[k][i+1];
        pend[k][5] = '0;
      end
      for (int i = 0; i < 5; i++) aq[k][i] = aq[k][i+1];
      aq[k][5] = 8'($urandom);
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < N; k++) begin
      chk("chk_valid", k, 16'(cv[k]), 16'(m_cv[k]));
      if (m_cv[k]) chk("mismatch", k, 16'(mm[k]), 16'(m_mm[k]));
      chk("err", k, 16'(er[k]), 16'(m_err[k]));
      chk("pass_cnt", k, pc[k], 16'(m_pass[k]));
      chk("fail_cnt", k, fc[k], 16'(m_fail[k]));
      chk("ff_op", k, 16'(fop[k]), 16'(m_op[k]));
      chk("ff_a", k, 16'(fa[k]), 16'(m_a[k]));
      chk("ff_b", k, 16'(fb[k]), 16'(m_b[k]));
      chk("ff_exp", k, 16'(fe[k]), 16'(m_e[k]));
      chk("ff_got", k, 16'(fg[k]), 16'(m_g[k]));
    end
  endtask

  // One clock: score outputs, drive inputs, advance the model.
  task automatic step(input bit v, input logic [2:0] o,
                      input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] got, input bit clr);
    @(negedge clk);
    compare_all();
    valid = v;
    op    = o;
    a     = x;
    b     = y;
    clear = clr;
    for (int k = 0; k < N; k++) begin
      if (v) aq[k][lat(k)] = got;
      if (v && !clr) begin
        pend[k][lat(k)].v  = 1'b1;
        pend[k][lat(k)].op = o;
        pend[k][lat(k)].a  = x;
        pend[k][lat(k)].b  = y;
        pend[k][lat(k)].e  = ref_alu(o, x, y);
        pend[k][lat(k)].g  = got;
      end
      alu_d[k] = aq[k][0];
    end
    @(posedge clk);
    model_edge(clr);
  endtask

  task automatic idle(input bit clr);
    step(1'b0, 3'($urandom), 8'($urandom), 8'($urandom),
         8'($urandom), clr);
  endtask

  task automatic rnd_step(input int unsigned pv, input int unsigned pcor,
                          input int unsigned pclr);
    logic [2:0] o;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] g;
    bit         v;
    bit         c;
    o = 3'($urandom);
    x = 8'($urandom);
    y = ($urandom_range(0, 3) == 0) ? x : 8'($urandom);
    v = $urandom_range(0, 99) < pv;
    g = ref_alu(o, x, y);
    if ($urandom_range(0, 99) < pcor) g = g ^ 8'($urandom_range(1, 255));
    c = $urandom_range(0, 99) < pclr;
    step(v, o, x, y, g, c);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    compare_all();
    valid = 1'b0;
    clear = 1'b0;
    #2 reset_n = 1'b0;
    for (int k = 0; k < N; k++) begin
      model_clear(k);
      for (int i = 0; i < 6; i++) aq[k][i] = 8'($urandom);
    end
    #1 compare_all();
    #1 reset_n = 1'b1;
    @(posedge clk);
    model_edge(1'b0);
  endtask

  initial begin
    reset_n = 1'b0;
    clear   = 1'b0;
    valid   = 1'b0;
    op      = '0;
    a       = '0;
    b       = '0;
    for (int k = 0; k < N; k++) begin
      alu_d[k] = '0;
      model_clear(k);
      for (int i = 0; i < 6; i++) aq[k][i] = '0;
    end
    repeat (2) @(negedge clk);
    compare_all();
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) step(1'b1, t_op[i], t_a[i], t_b[i], t_r[i], 1'b0);
    repeat (4) idle(1'b0);
    #2;
    chk("lit_pass_l0", 0, pc[0], 16'd8);
    chk("lit_pass_l2", 1, pc[1], 16'd8);
    chk("lit_pass_c4", 2, pc[2], 16'd8);
    chk("lit_err_l0", 0, 16'(er[0]), 16'd0);

    for (int i = 0; i < 8; i++)
      step(1'b1, t_op[i], t_a[i], t_b[i], (i == 2) ? 8'h08 : t_r[i], 1'b0);
    repeat (4) idle(1'b0);
    #2;
    chk("lit_fail", 0, fc[0], 16'd1);
    chk("lit_err", 0, 16'(er[0]), 16'd1);
    chk("lit_ff_op", 0, 16'(fop[0]), 16'h2);
    chk("lit_ff_a", 0, 16'(fa[0]), 16'h07);
    chk("lit_ff_b", 0, 16'(fb[0]), 16'h70);
    chk("lit_ff_exp", 0, 16'(fe[0]), 16'h07);
    chk("lit_ff_got", 0, 16'(fg[0]), 16'h08);
    chk("lit_pass_c4_sat", 2, pc[2], 16'hF);

    step(1'b1, 3'd0, 8'h01, 8'h01, 8'h03, 1'b0);
    repeat (4) idle(1'b0);
    #2;
    chk("lit_fail2", 1, fc[1], 16'd2);
    chk("lit_ff_got2", 1, 16'(fg[1]), 16'h08);
    chk("lit_ff_exp2", 1, 16'(fe[1]), 16'h07);

    idle(1'b1);
    step(1'b1, 3'd6, 8'h11, 8'h22, 8'h00, 1'b1);
    step(1'b1, 3'd1, 8'h10, 8'h01, 8'h00, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);
    #2;
    chk("lit_clr_fail", 1, fc[1], 16'd0);
    chk("lit_clr_err", 1, 16'(er[1]), 16'd0);
    chk("lit_clr_ff_got", 1, 16'(fg[1]), 16'd0);

    for (int i = 0; i < 20; i++) rnd_step(100, 0, 0);
    repeat (3) idle(1'b0);
    #2;
    chk("lit_sat_c4", 2, pc[2], 16'hF);
    chk("lit_cnt_l0", 0, pc[0], 16'd20);

    for (int i = 0; i < 300; i++) rnd_step(70, 10, 2);
    repeat (3) idle(1'b0);

    idle(1'b1);
    step(1'b1, 3'd0, 8'h12, 8'h34, 8'h46, 1'b0);
    step(1'b1, 3'd6, 8'h0F, 8'hF0, 8'hFF, 1'b0);
    pulse_reset();
    repeat (5) idle(1'b0);
    #2;
    chk("lit_rst_pass_l2", 1, pc[1], 16'd0);
    chk("lit_rst_pass_l0", 0, pc[0], 16'd0);

    @(negedge clk);
    compare_all();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
